// File: rtl/ad5302_ctrl.sv
// AD5302 dual 8-bit DAC controller: decodes UART commands, serialises A-then-B frames, then one shared LDAC pulse.
// Optional build macro AD5302_AUTO_LDAC_EN: every completed frame requests an LDAC pulse.
module ad5302_ctrl #(
  parameter logic [15:0] ADDRESS     = 16'hDAC0,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned LDAC_CYCLES = 11,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_reg,
  input  logic        uart_ready,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        dac_ldac_n,
  output logic        busy
);

  localparam int unsigned MAX_AB  = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SHIFT,
    S_GAP,
    S_LDAC,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    phase_q, phase_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic [1:0][WORD_W-1:0]  pend_word_q, pend_word_d;
  logic [1:0]              pend_v_q, pend_v_d;
  logic                    ldac_req_q, ldac_req_d;
  logic                    sync_n_q, sync_n_d;
  logic                    sclk_q, sclk_d;
  logic                    din_q, din_d;
  logic                    ldac_n_q, ldac_n_d;
  logic                    busy_q, busy_d;

  logic                    accept_c;
  logic                    ch_c;
  logic                    sel_c;
  logic [WORD_W-1:0]       word_c;
  logic                    unused_bits_c;

  assign accept_c      = uart_ready && (uart_reg[31:16] == ADDRESS);
  assign ch_c          = uart_reg[15];
  assign word_c        = {uart_reg[15:4], 4'b0000};
  assign sel_c         = ~pend_v_q[0];
  assign unused_bits_c = ^uart_reg[2:0];

  // Next-state, pending-slot and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    pend_word_d = pend_word_q;
    pend_v_d    = pend_v_q;
    ldac_req_d  = ldac_req_q;

    unique case (state_q)
      S_IDLE: begin
        if (|pend_v_q) begin
          state_d         = S_SYNC;
          cnt_d           = CNT_W'(CLK_DIV - 1);
          shift_d         = pend_word_q[sel_c];
          pend_v_d[sel_c] = 1'b0;
        end else if (ldac_req_q) begin
          state_d    = S_LDAC;
          cnt_d      = CNT_W'(LDAC_CYCLES - 1);
          ldac_req_d = 1'b0;
        end
      end
      S_SYNC: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = BIT_W'(WORD_W - 1);
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!phase_q) begin
          // Rising SCLK: present the next bit well ahead of the next falling edge
          phase_d = 1'b1;
          shift_d = {shift_q[WORD_W-2:0], 1'b0};
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end else if (bit_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
`ifdef AD5302_AUTO_LDAC_EN
          ldac_req_d = 1'b1;
`endif
        end else begin
          bit_d   = bit_q - BIT_W'(1);
          phase_d = 1'b0;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_LDAC: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepted commands land last so a same-cycle write beats the slot clear
    if (accept_c) begin
      pend_word_d[ch_c] = word_c;
      pend_v_d[ch_c]    = 1'b1;
      if (uart_reg[3]) ldac_req_d = 1'b1;
    end

    sync_n_d = !((state_d == S_SYNC) || (state_d == S_SHIFT));
    sclk_d   = !((state_d == S_SHIFT) && !phase_d);
    din_d    = sync_n_d ? 1'b0 : shift_d[WORD_W-1];
    ldac_n_d = (state_d != S_LDAC);
    busy_d   = (state_d != S_IDLE) || (|pend_v_d) || ldac_req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      pend_word_q <= '0;
      pend_v_q    <= '0;
      ldac_req_q  <= 1'b0;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      pend_word_q <= pend_word_d;
      pend_v_q    <= pend_v_d;
      ldac_req_q  <= ldac_req_d;
      sync_n_q    <= sync_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      ldac_n_q    <= ldac_n_d;
      busy_q      <= busy_d;
    end
  end

  assign dac_sync_n = sync_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ad5302_ctrl.sv
// Bench for ad5302_ctrl: pin-level frame/LDAC monitor checked against a queue of expected frame words.
`timescale 1ns/1ps
module tb_ad5302_ctrl;

  localparam int unsigned H         = 4;
  localparam int unsigned LDAC_W    = 11;
  localparam int unsigned GAP       = 8;
  localparam int unsigned FRAME_LOW = H + 32 * H;
`ifdef AD5302_AUTO_LDAC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] uart_reg = '0;
  logic        uart_ready = 1'b0;
  logic        dac_sync_n, dac_sclk, dac_din, dac_ldac_n, busy;

  always #5 clk = ~clk;

  ad5302_ctrl #(
    .ADDRESS(16'hDAC0), .CLK_DIV(H), .LDAC_CYCLES(LDAC_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_reg(uart_reg), .uart_ready(uart_ready),
    .dac_sync_n(dac_sync_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
    .dac_ldac_n(dac_ldac_n), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  int frames_seen = 0, ldac_seen = 0, ldac_at_frames = 0;
  int idle_edges = 0, overlap = 0, busy_cycles = 0;
  int low_cnt = 0, fall_cnt = 0, ldac_w = 0;
  logic [15:0] mon_word = '0;
  logic prev_sync = 1'b1, prev_sclk = 1'b1, prev_ldac = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pin monitor: rebuilds each frame from SCLK falls and times SYNC/LDAC
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0; fall_cnt = 0; mon_word = '0; ldac_w = 0;
      prev_sync = 1'b1; prev_sclk = 1'b1; prev_ldac = 1'b1;
    end else begin
      if (busy) busy_cycles++;
      if (!dac_sync_n) begin
        low_cnt++;
        if (prev_sclk && !dac_sclk) begin
          fall_cnt++;
          mon_word = {mon_word[14:0], dac_din};
        end
        if (!dac_ldac_n) overlap++;
      end else begin
        if (prev_sync && (dac_sclk != prev_sclk)) idle_edges++;
        if (!prev_sync) begin
          chk("frame_len", low_cnt, FRAME_LOW);
          chk("frame_falls", fall_cnt, 16);
          chk("frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("frame_word", mon_word, exp_q.pop_front());
          frames_seen++;
          low_cnt = 0; fall_cnt = 0;
        end
      end
      if (!dac_ldac_n) begin
        ldac_w++;
      end else if (!prev_ldac) begin
        chk("ldac_width", ldac_w, LDAC_W);
        ldac_seen++;
        ldac_at_frames = frames_seen;
        ldac_w = 0;
      end
      prev_sync = dac_sync_n; prev_sclk = dac_sclk; prev_ldac = dac_ldac_n;
    end
  end

  // Caller must be at a negedge; back-to-back calls strobe consecutive cycles
  task automatic send(input logic [31:0] cmd);
    uart_reg = cmd; uart_ready = 1'b1;
    @(negedge clk);
    uart_ready = 1'b0; uart_reg = '0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    repeat (20) @(negedge clk);
    while (busy && k < 5000) begin @(negedge clk); k++; end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_sync_low(input string name);
    int k;
    k = 0;
    while (dac_sync_n && k < 500) begin @(negedge clk); k++; end
    chk({name, "_sync_low"}, dac_sync_n, 0);
  endtask

  typedef struct {
    logic [31:0] cmd;
    bit          frame;
    logic [15:0] word;
    bit          ldac;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, l0, b0;

    vecs[0] = '{cmd: 32'hDAC0_5A58, frame: 1'b1, word: 16'h5A50, ldac: 1'b1};
    vecs[1] = '{cmd: 32'h1234_5A58, frame: 1'b0, word: 16'h0000, ldac: 1'b0};
    vecs[2] = '{cmd: 32'hDAC0_C3F0, frame: 1'b1, word: 16'hC3F0, ldac: AUTO};
    vecs[3] = '{cmd: 32'hDAC0_0007, frame: 1'b1, word: 16'h0000, ldac: AUTO};
    vecs[4] = '{cmd: 32'hDAC0_FFFF, frame: 1'b1, word: 16'hFFF0, ldac: 1'b1};
    vecs[5] = '{cmd: 32'hDAC1_5A58, frame: 1'b0, word: 16'h0000, ldac: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sync_n", dac_sync_n, 1);
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_din", dac_din, 0);
    chk("rst_ldac_n", dac_ldac_n, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("idle_hold", {dac_sync_n, dac_sclk, dac_din, dac_ldac_n, busy}, 5'b11010);
    end

    // Table-driven single commands
    for (int i = 0; i < 6; i++) begin
      f0 = frames_seen; l0 = ldac_seen; b0 = busy_cycles;
      if (vecs[i].frame) exp_q.push_back(vecs[i].word);
      send(vecs[i].cmd);
      chk($sformatf("v%0d_busy_set", i), busy, 32'(vecs[i].frame | vecs[i].ldac));
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_frames", i), frames_seen - f0, 32'(vecs[i].frame));
      chk($sformatf("v%0d_ldac", i), ldac_seen - l0, 32'(vecs[i].ldac));
      chk($sformatf("v%0d_queue", i), exp_q.size(), 0);
      if (!vecs[i].frame && !vecs[i].ldac) chk($sformatf("v%0d_no_busy", i), busy_cycles - b0, 0);
    end

    // Accept -> busy after one edge, SYNC low one edge later with bit15 on DIN
    l0 = ldac_seen;
    exp_q.push_back(16'h8000);
    send(32'hDAC0_8008);
    chk("lat_busy", busy, 1);
    chk("lat_sync_high", dac_sync_n, 1);
    @(negedge clk);
    chk("lat_sync_low", dac_sync_n, 0);
    chk("lat_sclk", dac_sclk, 1);
    chk("lat_din_msb", dac_din, 1);
    wait_idle("lat");
    chk("lat_ldac", ldac_seen - l0, 1);

    // Dual queue: B then A while a frame is running -> A, B, one LDAC after B
    f0 = frames_seen; l0 = ldac_seen;
    exp_q.push_back(16'h1230);
    send(32'hDAC0_1230);
    wait_sync_low("dual");
    exp_q.push_back(16'h2460);
    exp_q.push_back(16'hC3F0);
    send(32'hDAC0_C3F8);
    send(32'hDAC0_2468);
    wait_idle("dual");
    chk("dual_frames", frames_seen - f0, 3);
    chk("dual_ldac", ldac_seen - l0, 1);
    chk("dual_ldac_after_b", ldac_at_frames, f0 + 3);
    chk("dual_queue", exp_q.size(), 0);

    // Overwrite: latest A command wins
    f0 = frames_seen; l0 = ldac_seen;
    exp_q.push_back(16'h0AB0);
    send(32'hDAC0_0AB0);
    wait_sync_low("ovw");
    send(32'hDAC0_0110);
    send(32'hDAC0_0228);
    exp_q.push_back(16'h0220);
    wait_idle("ovw");
    chk("ovw_frames", frames_seen - f0, 2);
    chk("ovw_ldac", ldac_seen - l0, 1);
    chk("ovw_queue", exp_q.size(), 0);

    // Same-channel command during the selection cycle goes out in the next frame
    f0 = frames_seen; l0 = ldac_seen;
    exp_q.push_back(16'h0330);
    exp_q.push_back(16'h0440);
    send(32'hDAC0_0330);
    send(32'hDAC0_0448);
    wait_idle("sim");
    chk("sim_frames", frames_seen - f0, 2);
    chk("sim_ldac", ldac_seen - l0, 1);
    chk("sim_queue", exp_q.size(), 0);

    // Reset after 7 SCLK falls with another write pending
    exp_q.push_back(16'h9990);
    send(32'hDAC0_9998);
    for (int k = 0; k < 2000 && fall_cnt < 7; k++) @(negedge clk);
    chk("mid_falls", fall_cnt, 7);
    send(32'hDAC0_1118);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sync_n", dac_sync_n, 1);
    chk("mid_rst_sclk", dac_sclk, 1);
    chk("mid_rst_din", dac_din, 0);
    chk("mid_rst_ldac_n", dac_ldac_n, 1);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_seen; l0 = ldac_seen;
    repeat (400) @(negedge clk);
    chk("mid_no_frame", frames_seen - f0, 0);
    chk("mid_no_ldac", ldac_seen - l0, 0);
    chk("mid_busy", busy, 0);

    chk("sclk_idle_edges", idle_edges, 0);
    chk("ldac_during_sync", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad5302_ctrl.md
# ad5302_ctrl

UART-command-driven controller for the AD5302 dual 8-bit DAC. Decodes address-matched commands from the UART register bus and holds one pending word per channel. Schedules the serial writes A-before-B, generates SYNC/SCLK/DIN framing, then issues one shared LDAC pulse so both outputs update together. Sits between the UART command decoder and the DAC pins.

## Interface
- `ADDRESS`, 16'hDAC0: command match value for `uart_reg[31:16]`.
- `CLK_DIV`, 4: SCLK half-period H in `clk` cycles; must be ≥1.
- `LDAC_CYCLES`, 11: LDAC low width in `clk` cycles; must be ≥1.
- `GAP_CYCLES`, 8: minimum SYNC-high time between frames, in `clk` cycles; must be ≥1.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous active-low reset.
- `uart_reg` in 32: command word.
- `uart_ready` in 1: one-cycle strobe qualifying `uart_reg`.
- `dac_sync_n` out 1: AD5302 SYNC, active low.
- `dac_sclk` out 1: serial clock; idle high.
- `dac_din` out 1: serial data, MSB first.
- `dac_ldac_n` out 1: load DAC, active low.
- `busy` out 1: high while state ≠ S_IDLE, or while any pending flag or `ldac_req` is set.

## Operation
- Command accept condition: `uart_ready` high and `uart_reg[31:16]==ADDRESS`. Non-matching strobes are ignored.
- Command fields:
  - `[15]` channel (0=A, 1=B)
  - `[14]` BUF
  - `[13:12]` PD1:PD0
  - `[11:4]` data
  - `[3]` load request
  - `[2:0]` ignored
- Frame word sent = `{uart_reg[15:4], 4'b0000}`.
- Accepted command writes `pend_word[ch]` and sets `pend_v[ch]`. A newer command for the same channel overwrites the older one (latest wins). A set load bit sets the sticky `ldac_req`.
- State machine:
  - S_IDLE: if `pend_v[A]`, go to S_SYNC with channel A. Else if `pend_v[B]`, go to S_SYNC with channel B. Else if `ldac_req`, go to S_LDAC. Otherwise stay.
  - On leaving S_IDLE toward S_SYNC: copy the selected pending word into the 16-bit shifter and clear its flag. Exception: a same-channel command in that same cycle loads the new word and keeps the flag set.
  - S_SYNC (H cycles): `sync_n`=0, `sclk`=1, `din`=bit15.
  - S_SHIFT: 16 bits. Each bit is H cycles with `sclk`=0 (the DAC samples on the falling edge), then H cycles with `sclk`=1. `din` advances to the next bit on each rising edge. After bit 0's high phase, go to S_GAP.
  - S_GAP (GAP_CYCLES): `sync_n`=1, `sclk`=1, `din`=0. Then go to S_IDLE, which re-arbitrates with A priority.
  - S_LDAC (LDAC_CYCLES): `ldac_n`=0. Clear `ldac_req` on entry; a load request arriving during S_LDAC sets it again. Then go to S_DONE.
  - S_DONE (1 cycle): `ldac_n`=1, then go to S_IDLE.
- LDAC is only issued with no pending writes, so one pulse covers both channels.

## Timing
- Reset values: `dac_sync_n`=1, `dac_sclk`=1, `dac_din`=0, `dac_ldac_n`=1, `busy`=0. All pending flags, `ldac_req`, and the state are cleared.
- Reset asserted mid-frame or mid-LDAC forces all outputs to reset values immediately. No partial frame resumes.
- All outputs are registered.
- Accept → pending flag set: 1 edge. Pending → `sync_n` low: 1 further edge from S_IDLE.
- Frame length: H + 32·H cycles with `sync_n` low.
- Two queued channels with load requested: A frame, gap, B frame, gap, then LDAC.
- Commands are accepted in every state; nothing is ever back-pressured or dropped except by overwrite.
- SCLK edge count per frame is exactly 16 falling edges; no edges occur while `sync_n`=1.

## Configuration
- `AD5302_AUTO_LDAC_EN` defined: every completed frame sets `ldac_req`, regardless of bit 3.
- Not defined: LDAC is pulsed only when some accepted command had bit 3 set.

## Test plan
- Reset: hold `rst_n`=0 → `sync_n`=1, `sclk`=1, `din`=0, `ldac_n`=1, `busy`=0; release with no strobe → outputs unchanged for 1000 cycles.
- Single write, ADDRESS=16'hDAC0, CLK_DIV=4: `uart_reg`=32'hDAC0_5A58 → one 16-bit frame 0x5A50, 132 cycles with `sync_n` low, 16 SCLK falls, LDAC pulse 11 cycles, `busy` then drops.
- Address mismatch: `uart_reg`=32'h1234_5A58 strobed → no SYNC/LDAC activity, `busy` stays 0.
- Dual queue: B command then A command on consecutive cycles, both with load=1 → A frame first, then B frame, exactly one LDAC pulse after the B gap.
- Overwrite/simultaneous: during A frame send A=0x11 then A=0x22 → next A frame carries data 0x22 only; an A command in the S_IDLE→S_SYNC selection cycle is written in a following frame.
- Reset mid-frame after 7 SCLK falls → outputs at reset values within the same cycle, pending cleared, no frame after release; with `AD5302_AUTO_LDAC_EN`, a load=0 write still yields an LDAC pulse.
